// File: rtl/dac_soft_gain.sv
// dac_soft_gain
//   Per-sample digital volume / soft-mute stage running at the base sample
//   rate. It sits directly upstream of the first interpolation stage, and its
//   dout feeds that stage's 24-bit data input. The applied gain moves toward
//   the requested target in fixed steps, which avoids zipper noise. After
//   reset the gain starts at zero, so the output fades in (soft start).
//
// Ports
//   clock_in     in   1    sample clock, one sample per rising edge
//   rstn         in   1    asynchronous, active-low reset
//   din          in   DW   signed input sample
//   gain_target  in   GW   requested gain, unsigned Q1.15 (0x8000 = 1.0)
//   mute         in   1    1 = ramp gain to 0, 0 = ramp gain to gain_target
//   dout         out  DW   signed, rounded and saturated output sample
//   gain_cur     out  GW   gain currently applied to the datapath
//   ramping      out  1    gain is still moving toward its target
//   muted        out  1    gain has reached zero while mute is requested
//   sat_flag     out  1    dout was clipped on the most recent edge

module dac_soft_gain #(
   parameter int             DW        = 24,
   parameter int             GW        = 16,
   parameter logic [GW-1:0]  RAMP_STEP = 16'h0100
) (
   input  logic          clock_in,
   input  logic          rstn,
   input  logic [DW-1:0] din,
   input  logic [GW-1:0] gain_target,
   input  logic          mute,
   output logic [DW-1:0] dout,
   output logic [GW-1:0] gain_cur,
   output logic          ramping,
   output logic          muted,
   output logic          sat_flag
);

   localparam logic [1:0] ST_MUTED     = 2'd0;
   localparam logic [1:0] ST_RAMP_UP   = 2'd1;
   localparam logic [1:0] ST_RAMP_DOWN = 2'd2;
   localparam logic [1:0] ST_STEADY    = 2'd3;

   localparam int PW = DW + GW + 1;

   logic [1:0]          state;
   logic [1:0]          next_state;
   logic [GW-1:0]       tgt;
   logic [GW-1:0]       next_gain;
   logic [GW:0]         up_sum;
   logic [GW:0]         dn_diff;

   logic signed [PW-1:0] product;
   logic signed [PW-1:0] rounded;
   logic signed [PW-1:0] shifted;
   logic [PW-DW:0]       high_bits;
   logic [DW-1:0]        sat_value;
   logic                 clip;

   // Gain ramp. Both step results are computed one bit wider than the gain so
   // that the upward sum cannot wrap and the downward difference exposes a
   // borrow. Either way the step is clamped to the target, so the ramp lands
   // exactly on it and never overshoots.
   always_comb begin
      tgt     = mute ? '0 : gain_target;
      up_sum  = {1'b0, gain_cur} + {1'b0, RAMP_STEP};
      dn_diff = {1'b0, gain_cur} - {1'b0, RAMP_STEP};
      next_gain = gain_cur;
      if (gain_cur < tgt) begin
         if (up_sum > {1'b0, tgt}) begin
            next_gain = tgt;
         end else begin
            next_gain = up_sum[GW-1:0];
         end
      end else if (gain_cur > tgt) begin
         if (dn_diff[GW] || (dn_diff[GW-1:0] < tgt)) begin
            next_gain = tgt;
         end else begin
            next_gain = dn_diff[GW-1:0];
         end
      end
   end

   // The state is decided from the gain the register will hold after this
   // edge. A target of zero without mute therefore settles in STEADY, not
   // MUTED.
   always_comb begin
      if ((next_gain == '0) && mute) begin
         next_state = ST_MUTED;
      end else if (next_gain == tgt) begin
         next_state = ST_STEADY;
      end else if (next_gain < tgt) begin
         next_state = ST_RAMP_UP;
      end else begin
         next_state = ST_RAMP_DOWN;
      end
   end

   // Multiply by the gain in use before this edge's update. Rounding adds half
   // an LSB of the Q1.15 result, and the arithmetic shift then rounds half
   // toward +inf. The result is in range only if every bit from the DW-1
   // position upward equals the sign bit.
   always_comb begin
      product   = $signed(din) * $signed({1'b0, gain_cur});
      rounded   = product + $signed({{(PW-15){1'b0}}, 1'b1, 14'b0});
      shifted   = rounded >>> 15;
      high_bits = shifted[PW-1:DW-1];
      clip      = !((high_bits == '0) || (high_bits == '1));
      if (shifted[PW-1]) begin
         sat_value = {1'b1, {(DW-1){1'b0}}};
      end else begin
         sat_value = {1'b0, {(DW-1){1'b1}}};
      end
   end

   // Output, gain and state registers. Reset drops the gain to zero right
   // away (hard mute), so the next ramp starts from zero again.
   always_ff @(posedge clock_in or negedge rstn) begin
      if (!rstn) begin
         dout     <= '0;
         sat_flag <= 1'b0;
         gain_cur <= '0;
         state    <= ST_MUTED;
      end else begin
         dout     <= clip ? sat_value : shifted[DW-1:0];
         sat_flag <= clip;
         gain_cur <= next_gain;
         state    <= next_state;
      end
   end

   assign ramping = (state == ST_RAMP_UP) || (state == ST_RAMP_DOWN);
   assign muted   = (state == ST_MUTED);

endmodule

// File: tb/tb_dac_soft_gain.sv
// tb_dac_soft_gain
//   Self-checking bench for dac_soft_gain. A behavioural model built from
//   plain integer arithmetic tracks the expected gain, output sample and
//   status flags. A compare process checks the DUT against the model on
//   every falling edge. Directed scenarios add literal expectations at
//   points whose values are known by hand: soft start, unity pass-through,
//   saturation, rounding, soft mute, ramp reversal, retarget and reset
//   mid-ramp.

module tb_dac_soft_gain;

   localparam int STEP = 256;

   logic        clock_in;
   logic        rstn;
   logic [23:0] din;
   logic [15:0] gain_target;
   logic        mute;
   logic [23:0] dout;
   logic [15:0] gain_cur;
   logic        ramping;
   logic        muted;
   logic        sat_flag;

   int testsRun;
   int testsFailed;

   int          mGain;
   logic [23:0] mDout;
   bit          mSat;
   bit          mRamp;
   bit          mMuted;

   dac_soft_gain dut (
      .clock_in    (clock_in),
      .rstn        (rstn),
      .din         (din),
      .gain_target (gain_target),
      .mute        (mute),
      .dout        (dout),
      .gain_cur    (gain_cur),
      .ramping     (ramping),
      .muted       (muted),
      .sat_flag    (sat_flag)
   );

   // Free-running sample clock with a 10 time-unit period.
   initial begin
      clock_in = 1'b0;
      forever #5 clock_in = ~clock_in;
   end

   // Behavioural model. It applies the ramp rule as min/max arithmetic on
   // integers, scales the sample with 64-bit math, and derives the status
   // flags from the post-update gain.
   always @(posedge clock_in or negedge rstn) begin
      int     t;
      int     ng;
      longint p;
      longint r;
      if (!rstn) begin
         mGain  <= 0;
         mDout  <= 24'h0;
         mSat   <= 1'b0;
         mRamp  <= 1'b0;
         mMuted <= 1'b1;
      end else begin
         t = mute ? 0 : int'(gain_target);
         if (mGain < t) begin
            ng = (mGain + STEP > t) ? t : mGain + STEP;
         end else if (mGain > t) begin
            ng = (mGain - STEP < t) ? t : mGain - STEP;
         end else begin
            ng = mGain;
         end
         p = longint'($signed(din)) * longint'(mGain);
         r = (p + 64'sd16384) >>> 15;
         if (r > 64'sd8388607) begin
            mDout <= 24'h7FFFFF;
            mSat  <= 1'b1;
         end else if (r < -64'sd8388608) begin
            mDout <= 24'h800000;
            mSat  <= 1'b1;
         end else begin
            mDout <= r[23:0];
            mSat  <= 1'b0;
         end
         mMuted <= (ng == 0) && mute;
         mRamp  <= !((ng == 0) && mute) && (ng != t);
         mGain  <= ng;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Compare the DUT against the model every cycle, away from the active edge.
   always @(negedge clock_in) begin
      checkOutput("model_dout", 32'(dout), 32'(mDout));
      checkOutput("model_gain", 32'(gain_cur), 32'(mGain));
      checkOutput("model_sat", 32'(sat_flag), 32'(mSat));
      checkOutput("model_ramping", 32'(ramping), 32'(mRamp));
      checkOutput("model_muted", 32'(muted), 32'(mMuted));
   end

   task automatic applyStimulus(input logic [23:0] d, input logic [15:0] g,
                                input logic m);
      din         = d;
      gain_target = g;
      mute        = m;
   endtask

   // Advance n rising edges; inputs change 1 time unit after each edge.
   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge clock_in);
         #1;
      end
   endtask

   // Wait (bounded) until the model's gain reaches a value.
   task automatic waitGain(input string name, input int value, input int budget);
      int n;
      n = 0;
      while ((mGain != value) && (n < budget)) begin
         stepCycles(1);
         n++;
      end
      testsRun++;
      if (mGain != value) begin
         testsFailed++;
         $display("[TB] FAIL %s: gain 0x%0h never reached 0x%0h", name, mGain, value);
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rstn = 1'b0;
      applyStimulus(24'h100000, 16'h8000, 1'b0);
      #2;
      checkOutput("reset_dout", 32'(dout), 32'h0);
      checkOutput("reset_gain", 32'(gain_cur), 32'h0);
      checkOutput("reset_muted", 32'(muted), 32'h1);
      checkOutput("reset_ramping", 32'(ramping), 32'h0);
      checkOutput("reset_sat", 32'(sat_flag), 32'h0);

      // Soft start: release reset between edges, then 128 steps of 0x0100.
      stepCycles(1);
      #2 rstn = 1'b1;
      stepCycles(127);
      checkOutput("t1_gain_7f00", 32'(gain_cur), 32'h7F00);
      checkOutput("t1_ramping", 32'(ramping), 32'h1);
      stepCycles(1);
      checkOutput("t1_gain_8000", 32'(gain_cur), 32'h8000);
      checkOutput("t1_steady", 32'(ramping), 32'h0);
      stepCycles(1);
      checkOutput("t1_dout", 32'(dout), 32'h100000);

      // Unity pass-through with random samples, then the negative full scale.
      for (int i = 0; i < 40; i++) begin
         applyStimulus(24'($urandom), 16'h8000, 1'b0);
         stepCycles(1);
      end
      applyStimulus(24'h123456, 16'h8000, 1'b0);
      stepCycles(1);
      checkOutput("t2_dout", 32'(dout), 32'h123456);
      applyStimulus(24'h800000, 16'h8000, 1'b0);
      stepCycles(1);
      checkOutput("t2_negfs_dout", 32'(dout), 32'h800000);
      checkOutput("t2_negfs_sat", 32'(sat_flag), 32'h0);

      // Saturation at the maximum gain, then rounding at half gain.
      applyStimulus(24'h0, 16'hFFFF, 1'b0);
      waitGain("t3_ramp_ffff", 16'hFFFF, 300);
      applyStimulus(24'h7FFFFF, 16'hFFFF, 1'b0);
      stepCycles(1);
      checkOutput("t3_pos_dout", 32'(dout), 32'h7FFFFF);
      checkOutput("t3_pos_sat", 32'(sat_flag), 32'h1);
      applyStimulus(24'h800000, 16'hFFFF, 1'b0);
      stepCycles(1);
      checkOutput("t3_neg_dout", 32'(dout), 32'h800000);
      checkOutput("t3_neg_sat", 32'(sat_flag), 32'h1);
      applyStimulus(24'h0, 16'h4000, 1'b0);
      waitGain("t3_ramp_4000", 16'h4000, 300);
      applyStimulus(24'd3, 16'h4000, 1'b0);
      stepCycles(1);
      checkOutput("t3_rnd_pos", 32'(dout), 32'h2);
      applyStimulus(24'hFFFFFD, 16'h4000, 1'b0);
      stepCycles(1);
      checkOutput("t3_rnd_neg", 32'(dout), 32'hFFFFFF);
      checkOutput("t3_rnd_sat", 32'(sat_flag), 32'h0);

      // Soft mute from unity gain.
      applyStimulus(24'h100000, 16'h8000, 1'b0);
      waitGain("t4_ramp_8000", 16'h8000, 300);
      applyStimulus(24'h100000, 16'h8000, 1'b1);
      stepCycles(1);
      checkOutput("t4_down_gain", 32'(gain_cur), 32'h7F00);
      checkOutput("t4_down_ramping", 32'(ramping), 32'h1);
      waitGain("t4_ramp_0", 0, 300);
      checkOutput("t4_muted", 32'(muted), 32'h1);
      stepCycles(1);
      checkOutput("t4_dout_zero", 32'(dout), 32'h0);

      // Reverse the ramp halfway down, then retarget by less than one step.
      applyStimulus(24'h100000, 16'h8000, 1'b0);
      waitGain("t5_ramp_8000", 16'h8000, 300);
      applyStimulus(24'h100000, 16'h8000, 1'b1);
      waitGain("t5_ramp_4000", 16'h4000, 300);
      applyStimulus(24'h100000, 16'h8000, 1'b0);
      stepCycles(1);
      checkOutput("t5_reverse_gain", 32'(gain_cur), 32'h4100);
      checkOutput("t5_reverse_ramping", 32'(ramping), 32'h1);
      waitGain("t5_back_8000", 16'h8000, 300);
      applyStimulus(24'h100000, 16'h80F0, 1'b0);
      stepCycles(1);
      checkOutput("t5_retarget_gain", 32'(gain_cur), 32'h80F0);
      checkOutput("t5_retarget_steady", 32'(ramping), 32'h0);

      // Reset during a ramp, then a repeated soft start.
      applyStimulus(24'h100000, 16'h8000, 1'b1);
      waitGain("t6_ramp_0", 0, 300);
      applyStimulus(24'h100000, 16'h8000, 1'b0);
      waitGain("t6_ramp_3000", 16'h3000, 300);
      #2 rstn = 1'b0;
      #1;
      checkOutput("t6_reset_gain", 32'(gain_cur), 32'h0);
      checkOutput("t6_reset_dout", 32'(dout), 32'h0);
      checkOutput("t6_reset_muted", 32'(muted), 32'h1);
      stepCycles(2);
      #2 rstn = 1'b1;
      stepCycles(128);
      checkOutput("t6_gain_8000", 32'(gain_cur), 32'h8000);
      stepCycles(1);
      checkOutput("t6_dout", 32'(dout), 32'h100000);

      stepCycles(2);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
